// File: rtl/data_memory_arbiter.sv
// Arbiter for one single-port data memory shared by the pipeline core and a debug/loader port.
// The core has priority; a debug request that has waited STARVE_LIMIT cycles takes one slot from the core.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | debug may be granted this cycle
// DBG_RESP | debug read data returns from memory; dbg_ack pulses
module data_memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic [31:0] core_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, DBG_RESP} state_t;

  localparam logic [3:0] LIMIT        = 4'(STARVE_LIMIT);
  localparam logic       OWNER_CORE   = 1'b0;
  localparam logic       OWNER_DEBUG  = 1'b1;

  state_t      state;
  state_t      state_next;
  logic [3:0]  starve_cnt;
  logic        rdata_owner;
  logic        rdata_valid;
  logic        dbg_we_q;
  logic        dbg_grant;
  logic        core_grant;

  assign dbg_grant  = !reset && (state == IDLE) && dbg_req &&
                      (!core_req || (starve_cnt == LIMIT));
  assign core_grant = !reset && core_req && !dbg_grant;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (dbg_grant) state_next = DBG_RESP;
      DBG_RESP: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // The read-data owner and the debug write flag steer the response cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt  <= 4'd0;
      rdata_owner <= OWNER_CORE;
      rdata_valid <= 1'b0;
      dbg_we_q    <= 1'b0;
    end else begin
      if (dbg_grant || !dbg_req)
        starve_cnt <= 4'd0;
      else if (starve_cnt < LIMIT)
        starve_cnt <= starve_cnt + 4'd1;

      if (dbg_grant) begin
        rdata_owner <= OWNER_DEBUG;
        dbg_we_q    <= dbg_we;
      end else if (core_grant) begin
        rdata_owner <= OWNER_CORE;
      end
      rdata_valid <= dbg_grant || core_grant;
    end
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    core_stall = 1'b0;
    dbg_ack    = 1'b0;
    dbg_rdata  = 32'd0;
    core_rdata = 32'd0;

    if (dbg_grant) begin
      mem_en     = 1'b1;
      mem_we     = dbg_we;
      mem_addr   = dbg_addr;
      mem_wdata  = dbg_wdata;
      core_stall = core_req;
    end else if (core_grant) begin
      mem_en     = 1'b1;
      mem_we     = core_we;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
    end

    if (!reset && state == DBG_RESP) begin
      dbg_ack = 1'b1;
      if (rdata_owner == OWNER_DEBUG && !dbg_we_q) dbg_rdata = mem_rdata;
    end

    if (!reset && rdata_valid && rdata_owner == OWNER_CORE)
      core_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: u0 uses the default starvation limit, u1 uses a limit of 1.
// Both share stimulus; each has its own behavioural synchronous memory.
module tb_data_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;

  logic        stall0, ack0, en0, we0;
  logic [31:0] crd0, drd0, addr0, wd0, mrd0;
  logic        stall1, ack1, en1, we1;
  logic [31:0] crd1, drd1, addr1, wd1, mrd1;

  logic [31:0] mem0 [0:63];
  logic [31:0] mem1 [0:63];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  data_memory_arbiter #(.STARVE_LIMIT(4)) u0 (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(stall0), .core_rdata(crd0),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(ack0), .dbg_rdata(drd0),
    .mem_en(en0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0), .mem_rdata(mrd0)
  );

  data_memory_arbiter #(.STARVE_LIMIT(1)) u1 (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(stall1), .core_rdata(crd1),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(ack1), .dbg_rdata(drd1),
    .mem_en(en1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1), .mem_rdata(mrd1)
  );

  always @(posedge clock) begin
    if (en0) begin
      if (we0) mem0[addr0[7:2]] <= wd0;
      else     mrd0 <= mem0[addr0[7:2]];
    end
  end

  always @(posedge clock) begin
    if (en1) begin
      if (we1) mem1[addr1[7:2]] <= wd1;
      else     mrd1 <= mem1[addr1[7:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic sample;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    next_cycle;

    // requests present during reset must not reach memory
    core_req = 1; core_we = 1; dbg_req = 1; dbg_we = 1;
    sample;
    check("rst_mem_en", {31'b0, en0}, 0);
    check("rst_mem_we", {31'b0, we0}, 0);
    check("rst_stall", {31'b0, stall0}, 0);
    check("rst_ack", {31'b0, ack0}, 0);
    check("rst_core_rdata", crd0, 0);
    check("rst_dbg_rdata", drd0, 0);
    next_cycle;
    reset = 0; core_req = 0; core_we = 0; dbg_req = 0; dbg_we = 0;
    sample;
    check("idle_mem_en", {31'b0, en0}, 0);
    check("idle_mem_we", {31'b0, we0}, 0);
    next_cycle;

    // core store 0xDEADBEEF to 0x10, then load it back
    core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
    sample;
    check("cst_mem_en", {31'b0, en0}, 1);
    check("cst_mem_we", {31'b0, we0}, 1);
    check("cst_stall", {31'b0, stall0}, 0);
    next_cycle;
    core_we = 0;
    sample;
    check("cld_mem_en", {31'b0, en0}, 1);
    check("cld_mem_addr", addr0, 32'h10);
    check("cld_mem_we", {31'b0, we0}, 0);
    check("cld_stall", {31'b0, stall0}, 0);
    next_cycle;
    core_req = 0;
    sample;
    check("cld_rdata", crd0, 32'hDEADBEEF);
    check("cld_idle_en", {31'b0, en0}, 0);
    next_cycle;

    // debug write 0x12345678 to 0x20 with the core idle
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678;
    sample;
    check("dwr_mem_en", {31'b0, en0}, 1);
    check("dwr_mem_we", {31'b0, we0}, 1);
    check("dwr_mem_addr", addr0, 32'h20);
    check("dwr_mem_wdata", wd0, 32'h12345678);
    check("dwr_ack_early", {31'b0, ack0}, 0);
    next_cycle;
    dbg_req = 0; dbg_we = 0;
    sample;
    check("dwr_ack", {31'b0, ack0}, 1);
    check("dwr_rdata_zero", drd0, 0);
    check("dwr_resp_en", {31'b0, en0}, 0);
    next_cycle;
    core_req = 1; core_addr = 32'h20;
    sample;
    check("dwr_cld_en", {31'b0, en0}, 1);
    next_cycle;
    core_req = 0;
    sample;
    check("dwr_cld_rdata", crd0, 32'h12345678);
    check("dwr_noack", {31'b0, ack0}, 0);
    next_cycle;

    // starvation override, limit 4: core owns cycles 0-3, debug cycle 4
    core_req = 1; core_addr = 32'h10; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    for (int c = 0; c < 5; c++) begin
      sample;
      check($sformatf("stv_addr_c%0d", c), addr0, (c == 4) ? 32'h20 : 32'h10);
      check($sformatf("stv_stall_c%0d", c), {31'b0, stall0}, (c == 4) ? 1 : 0);
      check($sformatf("stv_en_c%0d", c), {31'b0, en0}, 1);
      next_cycle;
    end
    dbg_req = 0;
    sample;
    check("stv_ack", {31'b0, ack0}, 1);
    check("stv_dbg_rdata", drd0, 32'h12345678);
    check("stv_resp_core_addr", addr0, 32'h10);
    check("stv_resp_stall", {31'b0, stall0}, 0);
    next_cycle;
    core_req = 0;
    sample;
    check("stv_done_ack", {31'b0, ack0}, 0);
    next_cycle;

    // debug request held through ack: no grant in DBG_RESP, re-grant two cycles later
    dbg_req = 1; dbg_addr = 32'h10;
    sample;
    check("hold_grant0", {31'b0, en0}, 1);
    next_cycle;
    sample;
    check("hold_ack1", {31'b0, ack0}, 1);
    check("hold_nogrant1", {31'b0, en0}, 0);
    check("hold_rdata1", drd0, 32'hDEADBEEF);
    next_cycle;
    sample;
    check("hold_regrant2", {31'b0, en0}, 1);
    check("hold_noack2", {31'b0, ack0}, 0);
    next_cycle;
    dbg_req = 0;
    sample;
    check("hold_ack3", {31'b0, ack0}, 1);
    next_cycle;

    // reset during the DBG_RESP cycle drops the ack
    dbg_req = 1; dbg_addr = 32'h10;
    sample;
    check("rsr_grant", {31'b0, en0}, 1);
    next_cycle;
    reset = 1; core_req = 1; core_addr = 32'h10;
    sample;
    check("rsr_ack", {31'b0, ack0}, 0);
    check("rsr_en", {31'b0, en0}, 0);
    check("rsr_stall", {31'b0, stall0}, 0);
    next_cycle;
    reset = 0; core_req = 0;
    sample;
    check("rsr_starve", {28'b0, u0.starve_cnt}, 0);
    check("rsr_idle_grant", {31'b0, en0}, 1);
    check("rsr_idle_addr", addr0, 32'h10);
    next_cycle;
    dbg_req = 0;
    sample;
    check("rsr_ack_after", {31'b0, ack0}, 1);
    next_cycle;

    // limit 1, both requesting every cycle: grants alternate core / debug
    reset = 1;
    next_cycle;
    reset = 0;
    core_req = 1; core_addr = 32'h10; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    for (int c = 0; c < 6; c++) begin
      sample;
      check($sformatf("alt_stall_c%0d", c), {31'b0, stall1}, c % 2);
      check($sformatf("alt_addr_c%0d", c), addr1, (c % 2 == 1) ? 32'h20 : 32'h10);
      if (c > 0) check($sformatf("alt_ack_c%0d", c), {31'b0, ack1}, (c % 2 == 0) ? 1 : 0);
      next_cycle;
    end
    core_req = 0; dbg_req = 0;
    next_cycle;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, legal 1..15: consecutive waiting cycles after which a debug request overrides the core.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port core_req, input, 1: pipeline stage-4a memory access (valid load or store).
REQ-005 SHALL have port core_we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port core_addr, input, 32: core byte address.
REQ-007 SHALL have port core_wdata, input, 32: core store data.
REQ-008 SHALL have port core_stall, output, 1: stalls the pipeline; the core holds all core_* inputs while high.
REQ-009 SHALL have port core_rdata, output, 32: core load data, one cycle after grant.
REQ-010 SHALL have ports dbg_req (input, 1), dbg_we (input, 1), dbg_addr (input, 32) and dbg_wdata (input, 32): debug/loader request, held stable until ack.
REQ-011 SHALL have ports dbg_ack (output, 1) and dbg_rdata (output, 32): one-cycle completion pulse and load data.
REQ-012 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32) and mem_rdata (input, 32): single-port synchronous data memory with 1-cycle read latency.

Function
REQ-013 SHALL implement two states: IDLE and DBG_RESP.
REQ-014 SHALL, in IDLE with dbg_req=1 and (core_req=0 or starve_cnt==STARVE_LIMIT), grant debug: mem_* driven from dbg_* combinationally, mem_en=1, next state DBG_RESP.
REQ-015 SHALL assert core_stall combinationally in a debug-grant cycle when core_req=1, and SHALL hold it low in all other cycles.
REQ-016 SHALL, in any cycle with core_req=1 and no debug grant, grant the core: mem_* driven from core_*, mem_en=1, core_stall=0.
REQ-017 SHALL drive mem_en=0 when nothing is granted; mem_we SHALL be 0 whenever mem_en=0.
REQ-018 SHALL, in DBG_RESP, pulse dbg_ack=1 for exactly one cycle with dbg_rdata=mem_rdata, and SHALL return to IDLE next cycle.
REQ-019 SHALL NOT grant debug in DBG_RESP, even with dbg_req still high; the core MAY be granted in DBG_RESP.
REQ-020 SHALL keep a 4-bit starve_cnt: +1 per cycle in which dbg_req=1 and debug is not granted, saturating at STARVE_LIMIT; cleared to 0 on a debug grant or while dbg_req=0.
REQ-021 SHALL keep a registered rdata_owner flag (core/debug) set at each grant; core_rdata=mem_rdata in the cycle after a core grant, otherwise 0.
REQ-022 SHALL give debug writes mem_we=dbg_we; dbg_rdata SHALL be 0 for a debug write ack.
REQ-023 SHALL allow the requester to raise a new dbg_req the cycle after dbg_ack; the minimum debug issue interval is 2 cycles.
REQ-024 SHALL produce at most one mem_en=1 grant per cycle.

Reset
REQ-025 SHALL, with reset=1 at a clock edge, set state=IDLE, starve_cnt=0 and rdata_owner=core.
REQ-026 SHALL drive dbg_ack=0 and core_stall=0 during and after reset until a new grant, so that an ack pending in DBG_RESP is dropped.
REQ-027 SHALL drive mem_en=0, mem_we=0, and core_rdata=0 and dbg_rdata=0 while reset=1.

Verification
REQ-028 SHALL cover: idle core load to addr 0x10, mem holds 0xDEADBEEF -> mem_en=1 that cycle, core_rdata=0xDEADBEEF next cycle, core_stall never high.
REQ-029 SHALL cover: dbg write addr 0x20 data 0x12345678 with core idle -> grant same cycle, dbg_ack next cycle; a following core load of 0x20 returns 0x12345678.
REQ-030 SHALL cover: core_req held high continuously with dbg_req raised at cycle 0, STARVE_LIMIT=4 -> core granted cycles 0-3, debug granted cycle 4 with core_stall=1 only in cycle 4, dbg_ack in cycle 5.
REQ-031 SHALL cover: dbg_req held high through the ack cycle -> no second debug grant in DBG_RESP; re-grant no earlier than 2 cycles after the first.
REQ-032 SHALL cover: reset asserted in the DBG_RESP cycle -> dbg_ack=0, state IDLE; starve_cnt=0 checked after release.
REQ-033 SHALL cover: STARVE_LIMIT=1 with both requesting every cycle -> grants alternate core and debug, and core_stall=1 on every debug-grant cycle.
